// File: rtl/e_mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Valid/ready: start qualifies op for one cycle; the unit is ready whenever busy==0.
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             rd_hi;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] MDUout;

    modport slave (
        input  start, op, SrcA, SrcB, rd_hi,
        output busy, stall_req, HI, LO, MDUout
    );

    modport master (
        output start, op, SrcA, SrcB, rd_hi,
        input  busy, stall_req, HI, LO, MDUout
    );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; the result of an
// accepted mult/div lands after a fixed per-op latency, mthi/mtlo write at once.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave bus,
    output logic   o_dbg_state
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt, w_lat;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;
    logic             w_is_arith, w_capture;

    logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_den, w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_is_arith = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    assign w_lat      = ((r_op == OP_MULT) || (r_op == OP_MULTU)) ? CW'(MULT_CYCLES)
                                                                   : CW'(DIV_CYCLES);

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide via magnitudes: truncation toward zero, remainder takes the
    // dividend's sign, and MIN / -1 wraps back to MIN with no special case.
    assign w_a_neg = (r_op == OP_DIV) && r_a[WIDTH-1];
    assign w_b_neg = (r_op == OP_DIV) && r_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - r_a) : r_a;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - r_b) : r_b;
    assign w_den   = (w_b_mag == '0) ? WIDTH'(1) : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (WIDTH'(0) - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (WIDTH'(0) - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_is_arith) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = CW'(1);
                        w_capture   = 1'b1;
                    end else if (bus.op == OP_MTHI) begin
                        w_hi_nxt = bus.SrcA;
                    end else if (bus.op == OP_MTLO) begin
                        w_lo_nxt = bus.SrcA;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == w_lat) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    case (r_op)
                        OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                        OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (r_b != '0) begin
                                w_hi_nxt = w_rem;
                                w_lo_nxt = w_quot;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_capture) begin
                r_op <= bus.op;
                r_a  <= bus.SrcA;
                r_b  <= bus.SrcB;
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.stall_req = (r_state == S_RUN) || (bus.start && w_is_arith);
    assign bus.HI        = r_hi;
    assign bus.LO        = r_lo;
    assign bus.MDUout    = bus.rd_hi ? r_hi : r_lo;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: two instances (32-bit 5/10 cycles, 16-bit 1/1 cycles) run the
// same scenarios against an arithmetic reference model.
module tb_e_mdu;
    logic clk;
    logic rst_n0, rst_n1;
    logic dbg0, dbg1;
    int   n_vec, n_err;
    logic [31:0] exp_hi[2];
    logic [31:0] exp_lo[2];
    logic [63:0] exp_q[$];

    e_mdu_if #(.WIDTH(32)) if0 ();
    e_mdu_if #(.WIDTH(16)) if1 ();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk(clk), .reset(rst_n0), .bus(if0.slave), .o_dbg_state(dbg0)
    );
    e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst_n1), .bus(if1.slave), .o_dbg_state(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int k);  return (k == 0) ? 32 : 16; endfunction
    function automatic int mc(input int k);   return (k == 0) ? 5 : 1;   endfunction
    function automatic int dc(input int k);   return (k == 0) ? 10 : 1;  endfunction
    function automatic logic [31:0] msk(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic get_busy(input int k);  return (k == 0) ? if0.busy : if1.busy; endfunction
    function automatic logic get_stall(input int k); return (k == 0) ? if0.stall_req : if1.stall_req; endfunction
    function automatic logic [31:0] get_hi(input int k);  return (k == 0) ? if0.HI : {16'h0, if1.HI}; endfunction
    function automatic logic [31:0] get_lo(input int k);  return (k == 0) ? if0.LO : {16'h0, if1.LO}; endfunction
    function automatic logic [31:0] get_mdu(input int k); return (k == 0) ? if0.MDUout : {16'h0, if1.MDUout}; endfunction

    task automatic set_rst(input int k, input logic v);
        if (k == 0) rst_n0 = v; else rst_n1 = v;
    endtask

    task automatic drive(input int k, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic rdh);
        if (k == 0) begin
            if0.start = s; if0.op = o; if0.SrcA = a; if0.SrcB = b; if0.rd_hi = rdh;
        end else begin
            if1.start = s; if1.op = o; if1.SrcA = a[15:0]; if1.SrcB = b[15:0]; if1.rd_hi = rdh;
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the w-bit operand values.
    function automatic void ref_exec(input int w, input int o, input logic [31:0] a,
                                     input logic [31:0] b, inout logic [31:0] hi,
                                     inout logic [31:0] lo);
        longint unsigned m, ua, ub, pu, qu, ru;
        longint sa, sb, q, r;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'h0, a} & m;
        ub = {32'h0, b} & m;
        sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
        sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
        case (o)
            1: begin pu = sa * sb; hi = 32'((pu >> w) & m); lo = 32'(pu & m); end
            2: begin pu = ua * ub; hi = 32'((pu >> w) & m); lo = 32'(pu & m); end
            3: if (sb != 0) begin
                   q = sa / sb; r = sa % sb; qu = q; ru = r;
                   lo = 32'(qu & m); hi = 32'(ru & m);
               end
            4: if (ub != 0) begin lo = 32'((ua / ub) & m); hi = 32'((ua % ub) & m); end
            5: hi = 32'(ua);
            6: lo = 32'(ua);
            default: ;
        endcase
    endfunction

    function automatic int exp_cycles(input int k, input int o);
        if (o == 1 || o == 2) return mc(k);
        if (o == 3 || o == 4) return dc(k);
        return 0;
    endfunction

    task automatic do_op(input int k, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic rdh, output int cyc,
                         output logic stall0);
        @(negedge clk);
        drive(k, 1'b1, o, a, b, rdh);
        #1 stall0 = get_stall(k);
        @(negedge clk);
        drive(k, 1'b0, 3'd0, 32'h0, 32'h0, rdh);
        cyc = 0;
        while (get_busy(k) === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset(input int k);
        @(negedge clk);
        set_rst(k, 1'b0);
        drive(k, 1'b1, 3'd1, 32'h3, 32'h5, 1'b0);
        @(negedge clk);
        set_rst(k, 1'b1);
        drive(k, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        exp_hi[k] = 32'h0; exp_lo[k] = 32'h0;
        #1;
        n_vec++; if (get_busy(k) !== 1'b0) begin n_err++; $display("FAIL reset_busy k=%0d got %b want 0", k, get_busy(k)); end
        n_vec++; if (get_hi(k) !== 32'h0) begin n_err++; $display("FAIL reset_hi k=%0d got %h want 0", k, get_hi(k)); end
        n_vec++; if (get_lo(k) !== 32'h0) begin n_err++; $display("FAIL reset_lo k=%0d got %h want 0", k, get_lo(k)); end
        n_vec++; if (get_stall(k) !== 1'b0) begin n_err++; $display("FAIL reset_stall k=%0d got %b want 0", k, get_stall(k)); end
    endtask

    task automatic test_arith(input int k, input string nm, input logic [2:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic st;
        ref_exec(wid(k), int'(o), a, b, exp_hi[k], exp_lo[k]);
        do_op(k, o, a & msk(k), b & msk(k), 1'b1, cyc, st);
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL %s_stall k=%0d got %b want 1", nm, k, st); end
        n_vec++; if (cyc != exp_cycles(k, int'(o))) begin n_err++; $display("FAIL %s_cycles k=%0d got %0d want %0d", nm, k, cyc, exp_cycles(k, int'(o))); end
        n_vec++; if (get_hi(k) !== exp_hi[k]) begin n_err++; $display("FAIL %s_hi k=%0d got %h want %h", nm, k, get_hi(k), exp_hi[k]); end
        n_vec++; if (get_lo(k) !== exp_lo[k]) begin n_err++; $display("FAIL %s_lo k=%0d got %h want %h", nm, k, get_lo(k), exp_lo[k]); end
        n_vec++; if (get_mdu(k) !== exp_hi[k]) begin n_err++; $display("FAIL %s_mdu k=%0d got %h want %h", nm, k, get_mdu(k), exp_hi[k]); end
    endtask

    task automatic test_mt_divzero(input int k);
        int cyc;
        logic st;
        do_op(k, 3'd5, 32'h1234, 32'h0, 1'b1, cyc, st);
        n_vec++; if (cyc != 0 || st !== 1'b0) begin n_err++; $display("FAIL mthi_busy k=%0d got cyc %0d stall %b want 0 0", k, cyc, st); end
        n_vec++; if (get_mdu(k) !== 32'h1234) begin n_err++; $display("FAIL mthi_mdu k=%0d got %h want 1234", k, get_mdu(k)); end
        do_op(k, 3'd6, 32'h5678, 32'h0, 1'b0, cyc, st);
        n_vec++; if (cyc != 0) begin n_err++; $display("FAIL mtlo_busy k=%0d got %0d want 0", k, cyc); end
        n_vec++; if (get_mdu(k) !== 32'h5678) begin n_err++; $display("FAIL mtlo_mdu k=%0d got %h want 5678", k, get_mdu(k)); end
        n_vec++; if (get_hi(k) !== 32'h1234) begin n_err++; $display("FAIL mtlo_keeps_hi k=%0d got %h want 1234", k, get_hi(k)); end
        exp_hi[k] = 32'h1234; exp_lo[k] = 32'h5678;
        test_arith(k, "divu0", 3'd4, 32'h9999, 32'h0);
        test_arith(k, "div0", 3'd3, 32'h4321, 32'h0);
        n_vec++; if (get_hi(k) !== 32'h1234 || get_lo(k) !== 32'h5678) begin n_err++; $display("FAIL div0_hold k=%0d got %h/%h want 1234/5678", k, get_hi(k), get_lo(k)); end
    endtask

    task automatic test_start_during_run(input int k);
        int n;
        logic [31:0] a, b, old_lo;
        n = dc(k);
        a = 32'hFFFF_FF9C & msk(k);
        b = 32'h7;
        old_lo = exp_lo[k];
        ref_exec(wid(k), 3, a, b, exp_hi[k], exp_lo[k]);
        @(negedge clk);
        drive(k, 1'b1, 3'd3, a, b, 1'b0);
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            if (i == n)      drive(k, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            else if (i == 3) drive(k, 1'b1, 3'd6, 32'hDEAD, 32'h0, 1'b0);
            else             drive(k, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
            #1;
            n_vec++; if (get_busy(k) !== 1'b1 || get_stall(k) !== 1'b1) begin n_err++; $display("FAIL run_busy k=%0d cyc %0d got %b/%b want 1/1", k, i, get_busy(k), get_stall(k)); end
            if (i == 1) begin
                n_vec++; if (get_mdu(k) !== old_lo) begin n_err++; $display("FAIL run_old_mdu k=%0d got %h want %h", k, get_mdu(k), old_lo); end
            end
            @(negedge clk);
        end
        drive(k, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        n_vec++; if (get_busy(k) !== 1'b0) begin n_err++; $display("FAIL run_done_busy k=%0d got %b want 0", k, get_busy(k)); end
        n_vec++; if (get_lo(k) !== exp_lo[k]) begin n_err++; $display("FAIL run_lo k=%0d got %h want %h", k, get_lo(k), exp_lo[k]); end
        n_vec++; if (get_hi(k) !== exp_hi[k]) begin n_err++; $display("FAIL run_hi k=%0d got %h want %h", k, get_hi(k), exp_hi[k]); end
        @(negedge clk);
        n_vec++; if (get_busy(k) !== 1'b0 || get_lo(k) !== exp_lo[k]) begin n_err++; $display("FAIL run_no_queue k=%0d got %b/%h want 0/%h", k, get_busy(k), get_lo(k), exp_lo[k]); end
    endtask

    task automatic test_reset_midrun(input int k);
        int rc;
        rc = (mc(k) < 2) ? mc(k) : 2;
        @(negedge clk);
        drive(k, 1'b1, 3'd1, 32'h5, 32'h7, 1'b0);
        @(negedge clk);
        drive(k, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i < rc; i++) @(negedge clk);
        set_rst(k, 1'b0);
        @(negedge clk);
        set_rst(k, 1'b1);
        exp_hi[k] = 32'h0; exp_lo[k] = 32'h0;
        #1;
        n_vec++; if (get_busy(k) !== 1'b0 || get_hi(k) !== 32'h0 || get_lo(k) !== 32'h0) begin n_err++; $display("FAIL midrun_reset k=%0d got %b %h %h want 0 0 0", k, get_busy(k), get_hi(k), get_lo(k)); end
        repeat (mc(k) + 3) @(negedge clk);
        n_vec++; if (get_busy(k) !== 1'b0 || get_hi(k) !== 32'h0 || get_lo(k) !== 32'h0) begin n_err++; $display("FAIL midrun_late k=%0d got %b %h %h want 0 0 0", k, get_busy(k), get_hi(k), get_lo(k)); end
    endtask

    task automatic test_random(input int k, input int iters);
        int cyc, sel;
        logic st, rdh;
        logic [2:0] o;
        logic [31:0] a, b, h, l;
        logic [63:0] e;
        for (int i = 0; i < iters; i++) begin
            o   = 3'($urandom_range(0, 7));
            rdh = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a = $urandom & msk(k);
            b = $urandom & msk(k);
            if (sel == 0) begin a = (k == 0) ? 32'h8000_0000 : 32'h8000; b = msk(k); end
            if (sel == 1) b = 32'h0;
            h = exp_hi[k]; l = exp_lo[k];
            ref_exec(wid(k), int'(o), a, b, h, l);
            exp_q.push_back({h, l});
            do_op(k, o, a, b, rdh, cyc, st);
            e = exp_q.pop_front();
            exp_hi[k] = e[63:32]; exp_lo[k] = e[31:0];
            n_vec++; if (cyc != exp_cycles(k, int'(o))) begin n_err++; $display("FAIL rnd_cycles k=%0d op %0d got %0d want %0d", k, o, cyc, exp_cycles(k, int'(o))); end
            n_vec++; if (st !== (o >= 3'd1 && o <= 3'd4)) begin n_err++; $display("FAIL rnd_stall k=%0d op %0d got %b", k, o, st); end
            n_vec++; if (get_hi(k) !== e[63:32]) begin n_err++; $display("FAIL rnd_hi k=%0d op %0d a %h b %h got %h want %h", k, o, a, b, get_hi(k), e[63:32]); end
            n_vec++; if (get_lo(k) !== e[31:0]) begin n_err++; $display("FAIL rnd_lo k=%0d op %0d a %h b %h got %h want %h", k, o, a, b, get_lo(k), e[31:0]); end
            n_vec++; if (get_mdu(k) !== (rdh ? e[63:32] : e[31:0])) begin n_err++; $display("FAIL rnd_mdu k=%0d rd_hi %b got %h", k, rdh, get_mdu(k)); end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            test_reset(k);
            test_arith(k, "mult", 3'd1, 32'hFFFF_FFFE, 32'h3);
            test_arith(k, "multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            test_arith(k, "div", 3'd3, 32'hFFFF_FFF9, 32'h2);
            test_arith(k, "divu", 3'd4, 32'hFFFF_FFF9, 32'h2);
            test_arith(k, "div_ovf", 3'd3, (k == 0) ? 32'h8000_0000 : 32'h8000, 32'hFFFF_FFFF);
            test_mt_divzero(k);
            test_start_during_run(k);
            test_reset_midrun(k);
            test_random(k, 40);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
